// File: rtl/nibble_serial_adder_ctrl.sv
// Serial W-bit adder: one 4-bit carry-lookahead slice walks the operands a nibble per cycle.
// Optional signed-overflow output is enabled with macro ADDER_OVF_EN.
module nibble_serial_adder_ctrl #(
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*WORDS-1:0]   a_in,
  input  logic [4*WORDS-1:0]   b_in,
  input  logic                 c_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*WORDS-1:0]   sum,
  output logic                 co,
`ifdef ADDER_OVF_EN
  output logic                 ovf,
`endif
  output logic                 busy
);

  localparam int unsigned W    = 4 * WORDS;
  localparam int unsigned IW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            cy_q, cy_d, co_q, co_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
`ifdef ADDER_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  logic [3:0]      nib_a, nib_b, g, p, s;
  logic [4:0]      c;

  // Shared 4-bit carry-lookahead slice fed by the currently indexed nibble.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < int'(WORDS); i++) begin
      if (idx_q == IW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
    g    = nib_a & nib_b;
    p    = nib_a ^ nib_b;
    c[0] = cy_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = p ^ c[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid && in_ready_q)    state_d = RUN;
      RUN:     if (idx_q == LAST)             state_d = DONE;
      DONE:    if (out_valid_q && out_ready)  state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values; out_valid rises one cycle after DONE is entered.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    cy_d        = cy_q;
    co_d        = co_q;
`ifdef ADDER_OVF_EN
    ovf_d       = ovf_q;
`endif
    out_valid_d = (state_q == DONE) && !(out_valid_q && out_ready);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d   = a_in;
          b_d   = b_in;
          cy_d  = c_in;
          idx_d = '0;
          sum_d = '0;
          co_d  = 1'b0;
`ifdef ADDER_OVF_EN
          ovf_d = 1'b0;
`endif
        end
      end
      RUN: begin
        for (int i = 0; i < int'(WORDS); i++) begin
          if (idx_q == IW'(i)) sum_d[4*i +: 4] = s;
        end
        cy_d = c[4];
        if (idx_q == LAST) begin
          co_d  = c[4];
`ifdef ADDER_OVF_EN
          ovf_d = c[3] ^ c[4];
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      cy_q        <= 1'b0;
      co_q        <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      cy_q        <= cy_d;
      co_q        <= co_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

`ifdef ADDER_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign sum       = sum_q;
  assign co        = co_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl (WORDS=4); ovf checks follow ADDER_OVF_EN.
module tb_nibble_serial_adder_ctrl;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 4 * WORDS;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, c_in, out_valid, out_ready, co, busy;
  logic [W-1:0]  a_in, b_in, sum;
`ifdef ADDER_OVF_EN
  logic          ovf;
`endif

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  nibble_serial_adder_ctrl #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
`ifdef ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t        e;
    logic [W:0]  t;
    t     = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    e.sum = t[W-1:0];
    e.co  = t[W];
    e.ovf = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Callers sit 1ns after a rising edge; the request is accepted on the next edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) chk("send_timeout", (W+1)'(in_ready), (W+1)'(1));
    a_in     = a;
    b_in     = b;
    c_in     = c;
    in_valid = 1'b1;
    q.push_back(model(a, b, c));
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    if (!out_valid) chk("out_timeout", (W+1)'(out_valid), (W+1)'(1));
  endtask

  // Result monitor: the transfer completes on the next edge, compare against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", (W+1)'(1), (W+1)'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", (W+1)'(sum), (W+1)'(e.sum));
        chk("co",  (W+1)'(co),  (W+1)'(e.co));
`ifdef ADDER_OVF_EN
        chk("ovf", (W+1)'(ovf), (W+1)'(e.ovf));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int early;
    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready",  (W+1)'(in_ready),  (W+1)'(1));
    chk("rst_out_valid", (W+1)'(out_valid), (W+1)'(0));
    chk("rst_busy",      (W+1)'(busy),      (W+1)'(0));
    chk("rst_sum",       (W+1)'(sum),       (W+1)'(0));
    chk("rst_co",        (W+1)'(co),        (W+1)'(0));
    step(); step();
    rst = 1'b0;
    step();

    // Latency: out_valid first seen after edge T+5, exactly one cycle wide.
    send(16'h1234, 16'h1111, 1'b0);
    early = 0;
    for (int k = 1; k <= 4; k++) begin
      if (out_valid) early++;
      step();
    end
    if (out_valid) early++;
    chk("lat_early", (W+1)'(early), (W+1)'(0));
    step();
    chk("lat_t5", (W+1)'(out_valid), (W+1)'(1));
    step();
    chk("one_wide", (W+1)'(out_valid), (W+1)'(0));

    send(16'hFFFF, 16'h0000, 1'b1);
    wait_out(); step();

    // Backpressure in DONE.
    out_ready = 1'b0;
    send(16'h00FF, 16'h0001, 1'b0);
    wait_out();
    for (int k = 0; k < 3; k++) begin
      chk("hold_sum",      (W+1)'(sum),       (W+1)'(16'h0100));
      chk("hold_in_ready", (W+1)'(in_ready),  (W+1)'(0));
      chk("hold_busy",     (W+1)'(busy),      (W+1)'(1));
      chk("hold_valid",    (W+1)'(out_valid), (W+1)'(1));
      step();
    end
    out_ready = 1'b1;
    step();
    chk("release_in_ready", (W+1)'(in_ready), (W+1)'(1));
    chk("release_busy",     (W+1)'(busy),     (W+1)'(0));

    // Reset on the second RUN cycle aborts the operation.
    send(16'h1234, 16'h4321, 1'b0);
    step();
    rst = 1'b1;
    q.delete();
    #1;
    chk("abort_in_ready",  (W+1)'(in_ready),  (W+1)'(1));
    chk("abort_out_valid", (W+1)'(out_valid), (W+1)'(0));
    chk("abort_busy",      (W+1)'(busy),      (W+1)'(0));
    chk("abort_sum",       (W+1)'(sum),       (W+1)'(0));
    chk("abort_co",        (W+1)'(co),        (W+1)'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    early = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) early++;
      step();
    end
    chk("abort_no_result", (W+1)'(early), (W+1)'(0));
    send(16'h0001, 16'h0001, 1'b0);
    wait_out(); step();

    // Request noise while busy must not disturb the accepted operands.
    send(16'h0F0F, 16'h0101, 1'b1);
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      a_in     = W'($urandom);
      b_in     = W'($urandom);
      c_in     = 1'($urandom);
      step();
    end
    in_valid = 1'b0;
    wait_out(); step();
    chk("noise_no_queue", (W+1)'(busy), (W+1)'(0));

`ifdef ADDER_OVF_EN
    send(16'h7FFF, 16'h0001, 1'b0); wait_out(); step();
    send(16'h8000, 16'h8000, 1'b0); wait_out(); step();
    send(16'h1234, 16'h1111, 1'b0); wait_out(); step();
`endif

    for (int k = 0; k < 24; k++) begin
      send(W'($urandom), W'($urandom), 1'($urandom));
      wait_out(); step();
    end

    repeat (4) step();
    chk("sb_empty", (W+1)'(q.size()), (W+1)'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

Interface
REQ-001 SHALL have parameter: WORDS, default 4, number of 4-bit slices per operand; operand width W = 4*WORDS.
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: in_valid  input  1  operand request valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept request.
REQ-006 SHALL have ports: a_in, b_in  input  W  operands; c_in  input  1  carry-in.
REQ-007 SHALL have port: out_valid  output  1  result valid.
REQ-008 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-009 SHALL have ports: sum  output  W  result; co  output  1  final carry-out.
REQ-010 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL contain exactly one 4-bit carry-lookahead slice (G=A&B, P=A^B, per-bit carries from G/P and slice carry-in); all W-bit addition SHALL be time-multiplexed through it.
REQ-012 SHALL implement FSM with states IDLE, RUN, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 IDLE: on in_valid & in_ready, latch a_in, b_in; carry register <= c_in; slice index <= 0; clear sum register; go RUN.
REQ-015 RUN: each cycle, slice adds nibble [index] of latched operands with carry register; write slice sum into sum[4*index+3:4*index]; carry register <= slice carry-out.
REQ-016 RUN: if index == WORDS-1 go DONE and load co from slice carry-out, else index <= index+1.
REQ-017 Latency: accept on edge T, out_valid high from edge T+WORDS+1 (T+5 for WORDS=4).
REQ-018 DONE: sum, co (and ovf) SHALL hold stable while out_ready is low; on out_ready go IDLE on next edge.
REQ-019 in_valid, a_in, b_in, c_in SHALL be ignored in RUN and DONE; no request queued.
REQ-020 Arithmetic SHALL be unsigned modulo 2^W; {co,sum} equals a_in+b_in+c_in exactly.
REQ-021 Index counter SHALL be ceil(log2(WORDS)) bits min 1, never exceed WORDS-1.
REQ-022 sum SHALL be registered; partial nibbles visible during RUN are not valid data.

Reset
REQ-023 rst high SHALL immediately force IDLE, index 0, carry register 0, sum 0, co 0, out_valid 0, busy 0, in_ready 1 (ovf 0 if present).
REQ-024 rst asserted mid-RUN or in DONE SHALL abort the operation with no result delivered; first request accepted on first edge after rst deasserts with in_valid high.

Configuration
REQ-025 Macro ADDER_OVF_EN: when defined, SHALL add port ovf  output  1  signed two's-complement overflow.
REQ-026 With ADDER_OVF_EN, on last RUN cycle ovf SHALL be registered as carry into bit W-1 XOR carry out of bit W-1, held through DONE, cleared on next accept.
REQ-027 Without ADDER_OVF_EN, ovf port and its logic SHALL not exist; all other behaviour identical.

Verification (WORDS=4)
REQ-028 a=0x1234, b=0x1111, c_in=0, out_ready=1 -> sum=0x2345, co=0, out_valid exactly 5 edges after accept, one cycle wide.
REQ-029 a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, co=1 (carry ripples through all four slices).
REQ-030 a=0x00FF, b=0x0001, out_ready low 3 cycles in DONE -> sum=0x0100 held, in_ready=0, busy=1; out_ready high -> IDLE, in_ready=1 next cycle.
REQ-031 rst pulsed on second RUN cycle -> all outputs reset values immediately; no out_valid; new request a=0x0001,b=0x0001 afterwards -> sum=0x0002.
REQ-032 in_valid toggled with changing operands during RUN -> result equals first-accepted operands only.
REQ-033 ADDER_OVF_EN defined: 0x7FFF+0x0001 -> sum=0x8000, co=0, ovf=1; 0x8000+0x8000 -> sum=0x0000, co=1, ovf=1; 0x1234+0x1111 -> ovf=0.
